// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : measures the duty code of a 2^WIDTH-clock PWM waveform and
//               flags malformed periods and stuck lines.
// Optional 2-flop input synchronizer: define PWM_CAPTURE_SYNC_EN.
// Revision    : 1.0
// ============================================================================
module pwm_capture #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid,
  output logic             period_err,
  output logic             stuck_lo,
  output logic             stuck_hi
);

  localparam int CW = WIDTH + 2;
  localparam logic [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_PERIOD = {2'b01, {WIDTH{1'b0}}};
  localparam logic [CW-1:0] C_STUCK  = {2'b10, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s;
  logic             rise;
  logic             prev_q, prev_d;
  logic [CW-1:0]    per_cnt_q, per_cnt_d;
  logic [CW-1:0]    hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             stuck_lo_q, stuck_lo_d;
  logic             stuck_hi_q, stuck_hi_d;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], pwm_in};
  end

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= sync_d;
  end

  assign s = sync_q[1];
`else
  assign s = pwm_in;
`endif

  assign rise = s & ~prev_q;

  // Both counters saturate at 2P so a dead line cannot wrap back into range.
  always_comb begin
    prev_d    = s;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise) begin
      per_cnt_d = C_ONE;
      hi_cnt_d  = C_ONE;
    end else begin
      if (per_cnt_q != C_STUCK)      per_cnt_d = per_cnt_q + C_ONE;
      if (s && hi_cnt_q != C_STUCK)  hi_cnt_d  = hi_cnt_q + C_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    stuck_lo_d = stuck_lo_q;
    stuck_hi_d = stuck_hi_q;
    case (state_q)
      ST_IDLE, ST_MEASURE: begin
        // Timeout wins over a coincident rise: a 2P spacing is a stuck line.
        if (per_cnt_q == C_STUCK) begin
          state_d = ST_STUCK;
          valid_d = 1'b1;
          if (s) begin
            stuck_hi_d = 1'b1;
            duty_d     = '1;
          end else begin
            stuck_lo_d = 1'b1;
            duty_d     = '0;
          end
        end else if (rise) begin
          state_d = ST_MEASURE;
          if (state_q == ST_MEASURE) begin
            if (per_cnt_q == C_PERIOD) begin
              duty_d  = hi_cnt_q[WIDTH-1:0];
              valid_d = 1'b1;
            end else begin
              perr_d  = 1'b1;
            end
          end
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_d    = ST_MEASURE;
          stuck_lo_d = 1'b0;
          stuck_hi_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= 1'b0;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      stuck_lo_q <= 1'b0;
      stuck_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      stuck_lo_q <= stuck_lo_d;
      stuck_hi_q <= stuck_hi_d;
    end
  end

  assign duty_out   = duty_q;
  assign valid      = valid_q;
  assign period_err = perr_q;
  assign stuck_lo   = stuck_lo_q;
  assign stuck_hi   = stuck_hi_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// tb_pwm_capture : directed period-by-period checks of pwm_capture.
// Revision       : 1.0
// ============================================================================
module tb_pwm_capture;

  localparam int WIDTH = 4;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic [WIDTH-1:0] duty_out;
  logic             valid;
  logic             period_err;
  logic             stuck_lo;
  logic             stuck_hi;

  int n_vec = 0;
  int n_bad = 0;
  int win_idx, win_valid, win_perr, win_first_valid;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .valid      (valid),
    .period_err (period_err),
    .stuck_lo   (stuck_lo),
    .stuck_hi   (stuck_hi)
  );

  // One waveform segment: rise, hi cycles high, remainder low (hi=0: all low).
  typedef struct {
    int len;
    int hi;
    int exp_valid;
    int exp_perr;
    int exp_duty;
    int exp_lo;
    int exp_hi;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_window();
    win_idx         = 0;
    win_valid       = 0;
    win_perr        = 0;
    win_first_valid = -1;
  endtask

  task automatic step(input logic p);
    pwm_in = p;
    @(posedge clk);
    #1;
    if (valid) begin
      if (win_first_valid < 0) win_first_valid = win_idx;
      win_valid++;
    end
    if (period_err) win_perr++;
    win_idx++;
  endtask

  task automatic gen(input int len, input int hi);
    for (int k = 0; k < len; k++) step(k < hi);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " duty_out"},   int'(duty_out),   0);
    check({tag, " valid"},      int'(valid),      0);
    check({tag, " period_err"}, int'(period_err), 0);
    check({tag, " stuck_lo"},   int'(stuck_lo),   0);
    check({tag, " stuck_hi"},   int'(stuck_hi),   0);
  endtask

  initial begin
    int first_lo;
    int valid_at_lo;

    vecs[0]  = '{16,  4, 0, 0,  0, 0, 0};
    vecs[1]  = '{16,  4, 1, 0,  4, 0, 0};
    vecs[2]  = '{16,  4, 1, 0,  4, 0, 0};
    vecs[3]  = '{16,  4, 1, 0,  4, 0, 0};
    vecs[4]  = '{16,  8, 1, 0,  4, 0, 0};
    vecs[5]  = '{16,  8, 1, 0,  8, 0, 0};
    vecs[6]  = '{16, 15, 1, 0,  8, 0, 0};
    vecs[7]  = '{16, 15, 1, 0, 15, 0, 0};
    vecs[8]  = '{16,  8, 1, 0, 15, 0, 0};
    vecs[9]  = '{16,  8, 1, 0,  8, 0, 0};
    vecs[10] = '{16,  0, 0, 0,  8, 0, 0};
    vecs[11] = '{16,  0, 1, 0,  0, 1, 0};
    vecs[12] = '{16,  8, 0, 0,  0, 0, 0};
    vecs[13] = '{16,  8, 1, 0,  8, 0, 0};
    vecs[14] = '{40, 40, 2, 0, 15, 0, 1};
    vecs[15] = '{ 4,  0, 0, 0, 15, 0, 1};
    vecs[16] = '{16,  8, 0, 0, 15, 0, 0};
    vecs[17] = '{16,  8, 1, 0,  8, 0, 0};
    vecs[18] = '{12,  8, 1, 0,  8, 0, 0};
    vecs[19] = '{12,  8, 0, 1,  8, 0, 0};
    vecs[20] = '{12,  8, 0, 1,  8, 0, 0};
    vecs[21] = '{16,  8, 0, 1,  8, 0, 0};
    vecs[22] = '{16,  8, 1, 0,  8, 0, 0};

    clear_window();
    rst    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 23; i++) begin
      clear_window();
      gen(vecs[i].len, vecs[i].hi);
      check($sformatf("row%0d valid_count", i), win_valid, vecs[i].exp_valid);
      check($sformatf("row%0d perr_count", i),  win_perr,  vecs[i].exp_perr);
      check($sformatf("row%0d duty_out", i),    int'(duty_out), vecs[i].exp_duty);
      check($sformatf("row%0d stuck_lo", i),    int'(stuck_lo), vecs[i].exp_lo);
      check($sformatf("row%0d stuck_hi", i),    int'(stuck_hi), vecs[i].exp_hi);
    end

    // Exact stuck_lo entry: the last rise was step 0 of the final row.
    first_lo    = -1;
    valid_at_lo = 0;
    for (int idx = 16; idx <= 40; idx++) begin
      step(1'b0);
      if (stuck_lo && first_lo < 0) begin
        first_lo    = idx;
        valid_at_lo = int'(valid);
      end
    end
    check("stuck_lo entry cycle", first_lo, 32 + LAT);
    check("stuck_lo entry valid", valid_at_lo, 1);
    check("stuck_lo duty_out", int'(duty_out), 0);

    // Relock, then reset mid-period while the line is low.
    gen(16, 8);
    clear_window();
    gen(16, 8);
    check("relock duty_out", int'(duty_out), 8);
    for (int k = 0; k < 10; k++) step(k < 8);
    rst = 1'b0;
    step(1'b0);
    rst = 1'b1;
    check_idle_outputs("midreset");
    for (int k = 0; k < 5; k++) step(1'b0);

    clear_window();
    gen(16, 8);
    check("post-reset rise1 valid_count", win_valid, 0);
    check("post-reset rise1 perr_count",  win_perr,  0);
    check("post-reset rise1 duty_out",    int'(duty_out), 0);
    clear_window();
    gen(16, 8);
    check("post-reset rise2 valid_count", win_valid, 1);
    check("post-reset rise2 valid_cycle", win_first_valid, LAT);
    check("post-reset rise2 duty_out",    int'(duty_out), 8);
    check("post-reset rise2 perr_count",  win_perr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle of an incoming PWM waveform and reports it as a WIDTH-bit code. It is the receive-side counterpart of the team's PWM generator: a generator driven with duty code D (period 2^WIDTH clocks, output high for D clocks) feeding this block yields duty_out = D. It sits on a feedback or monitoring path and flags malformed periods and stuck lines.

## Interface
- WIDTH, 4, duty code width; the nominal PWM period is P = 2^WIDTH clocks.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- pwm_in  input  1  PWM waveform under measurement.
- duty_out  output  WIDTH  last measured duty code (high cycles per period).
- valid  output  1  one-cycle pulse when duty_out has just been updated.
- period_err  output  1  one-cycle pulse when a period length other than P was observed.
- stuck_lo  output  1  level flag: no rising edge for 2P clocks and the line is low.
- stuck_hi  output  1  level flag: no rising edge for 2P clocks and the line is high.

## Operation
- s = sampled input (pwm_in directly, or synchronized per Configuration). prev = s delayed one clock. rise = s & ~prev.
- Counters per_cnt and hi_cnt, WIDTH+2 bits each, saturating at 2P.
- On a rise cycle: per_cnt <= 1, hi_cnt <= 1. Otherwise per_cnt <= per_cnt+1 and hi_cnt <= hi_cnt + s (both saturating).
- States:
  - IDLE (after reset): counters run. On rise -> MEASURE with no output, because the first period is unknown. If per_cnt reaches 2P -> STUCK.
  - MEASURE: on rise, if per_cnt == P then duty_out <= hi_cnt[WIDTH-1:0] and valid pulses. Otherwise period_err pulses and duty_out holds. Either way stay in MEASURE. If per_cnt reaches 2P -> STUCK.
  - STUCK: on entry, if s=0 set stuck_lo and duty_out <= 0; if s=1 set stuck_hi and duty_out <= 2^WIDTH-1. Pulse valid once on entry. On rise, clear both stuck flags and go to MEASURE with no output.
- hi_cnt == P cannot occur with per_cnt == P and a rise (the line must be low at least one cycle), so truncation to WIDTH bits is lossless.
- A rise spaced exactly 2P clocks from the previous one is a STUCK entry, not a period_err.

## Timing
- Reset values: duty_out=0, valid=0, period_err=0, stuck_lo=0, stuck_hi=0, state=IDLE, per_cnt=0, hi_cnt=0, prev=0 (sync flops 0).
- Reset is synchronous. Asserting rst mid-period discards partial counts. The first valid after release requires two rises.
- Latency without the macro: valid/period_err are high in the clock cycle after the edge that first samples pwm_in=1. With the macro, 2 cycles later.
- valid and period_err are mutually exclusive and never high for two consecutive cycles in MEASURE.
- STUCK entry: stuck_lo/stuck_hi assert, together with the valid pulse, in the cycle after per_cnt reaches 2P. They hold until the clock after the next rise.

## Configuration
- PWM_CAPTURE_SYNC_EN defined: s comes from a 2-flop synchronizer on pwm_in, which adds 2 cycles to every output latency. Measured values are unchanged.
- Not defined: s = pwm_in, for inputs already synchronous to clk (for example, the on-chip generator).

## Test plan
- Generator duty=4 for 4 periods -> first valid after the second rise; duty_out=4; valid pulses every 16 clocks; period_err never asserts.
- Duty changes 4 -> 8 -> 15 on period boundaries -> the duty_out sequence is 4, 8, 15. Each new value appears on the first full period at the new setting.
- Duty=0 (line constant low) -> 32 clocks after the last rise: stuck_lo=1, duty_out=0, single valid pulse. Restoring duty=8 -> stuck_lo clears, and duty_out=8 one period later.
- pwm_in forced high for 40 clocks -> stuck_hi=1, duty_out=15. The next rise clears stuck_hi.
- Rises spaced 12 clocks apart after lock at duty=8 -> period_err pulses, duty_out stays 8, valid stays low.
- rst low for 1 cycle mid-period at duty=8 -> all outputs 0. The next two rises produce no valid on the first and valid with duty_out=8 on the second. Repeat with PWM_CAPTURE_SYNC_EN and check the extra 2-cycle latency.
